// File: rtl/dw2_gen.sv
// dw2_gen: delta-weight generator for one hidden-to-output weight register.
// Computes dw = -ETA*delta*act in signed Q6.10 over two sequential multiply
// stages, then strobes the weight register's update (or initial-load) input.
module dw2_gen #(
  parameter logic signed [15:0] ETA  = 16'sd512,
  parameter int unsigned        FRAC = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               init_req,
  input  logic signed [15:0] delta,
  input  logic signed [15:0] act,
  output logic signed [15:0] dw,
  output logic               select_update,
  output logic               select_initial,
  output logic               busy,
  output logic               done
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_A = 3'd1,
    S_MUL_B = 3'd2,
    S_ISSUE = 3'd3,
    S_INIT  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [DW-1:0] r_d;
  logic signed [DW-1:0] r_a;
  logic signed [DW-1:0] r_p1;
  logic signed [DW-1:0] r_p2;
  logic signed [DW-1:0] r_dw;
  logic                 r_select_update;
  logic                 r_select_initial;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_capture;
  logic signed [PW-1:0] w_prod1;
  logic signed [PW-1:0] w_prod2;
  logic signed [DW-1:0] w_p1;
  logic signed [DW-1:0] w_p2;
  logic signed [DW-1:0] w_dw;

  // Clamp a 32-bit signed value into the 16-bit signed range.
  function automatic logic signed [DW-1:0] sat16(input logic signed [PW-1:0] x);
    if (x > 32'sd32767)       return 16'sh7FFF;
    else if (x < -32'sd32768) return 16'sh8000;
    else                      return DW'(x);
  endfunction

  // Product stages: full-width multiply, arithmetic (floor) shift, clamp.
  always_comb begin
    w_prod1 = PW'(r_d) * PW'(r_a);
    w_p1    = sat16(w_prod1 >>> FRAC);
    w_prod2 = PW'(r_p1) * PW'(ETA);
    w_p2    = sat16(w_prod2 >>> FRAC);
    w_dw    = (w_p2 == 16'sh8000) ? 16'sh7FFF : -w_p2;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; init_req has priority over start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (init_req) begin
          w_state_nxt = S_INIT;
        end else if (start) begin
          w_state_nxt = S_MUL_A;
          w_capture   = 1'b1;
        end
      end
      S_MUL_A: w_state_nxt = S_MUL_B;
      S_MUL_B: w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_IDLE;
      S_INIT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs, all derived from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d              <= '0;
      r_a              <= '0;
      r_p1             <= '0;
      r_p2             <= '0;
      r_dw             <= '0;
      r_select_update  <= 1'b0;
      r_select_initial <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      if (w_capture) begin
        r_d <= delta;
        r_a <= act;
      end
      if (r_state == S_MUL_A) r_p1 <= w_p1;
      if (r_state == S_MUL_B) begin
        r_p2 <= w_p2;
        r_dw <= w_dw;
      end
      r_select_update  <= (w_state_nxt == S_ISSUE);
      r_done           <= (w_state_nxt == S_ISSUE);
      r_select_initial <= (w_state_nxt == S_INIT);
      r_busy           <= (w_state_nxt != S_IDLE);
    end
  end

  assign dw             = r_dw;
  assign select_update  = r_select_update;
  assign select_initial = r_select_initial;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_dw2_gen.sv
// Directed bench for dw2_gen: nominal, floor, saturation, arbitration,
// ignore-while-busy, reset abort and input hold.
module tb_dw2_gen;

  logic clk = 1'b0;
  logic reset;
  logic start, init_req;
  logic signed [15:0] delta, act;
  logic signed [15:0] dw;
  logic select_update, select_initial, busy, done;

  logic start2, init_req2;
  logic signed [15:0] delta2, act2;
  logic signed [15:0] dw2;
  logic select_update2, select_initial2, busy2, done2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dw2_gen u_dut (
    .clk(clk), .reset(reset), .start(start), .init_req(init_req),
    .delta(delta), .act(act), .dw(dw), .select_update(select_update),
    .select_initial(select_initial), .busy(busy), .done(done)
  );

  dw2_gen #(.ETA(16'sd1024)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .init_req(init_req2),
    .delta(delta2), .act(act2), .dw(dw2), .select_update(select_update2),
    .select_initial(select_initial2), .busy(busy2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full computation on u_dut with cycle-exact strobe checks.
  task automatic do_mac(input string tag, input logic signed [15:0] d,
                        input logic signed [15:0] a, input logic signed [15:0] exp_p1,
                        input logic signed [15:0] exp_dw);
    delta = d; act = a; start = 1'b1;
    tick();                                   // edge k
    start = 1'b0;
    chk({tag, "_busy_k"}, 16'(busy), 16'd1);
    chk({tag, "_upd_k"}, 16'(select_update), 16'd0);
    tick();                                   // edge k+1
    chk({tag, "_p1"}, u_dut.r_p1, exp_p1);
    chk({tag, "_upd_k1"}, 16'(select_update), 16'd0);
    tick();                                   // edge k+2
    chk({tag, "_upd_k2"}, 16'(select_update), 16'd1);
    chk({tag, "_done_k2"}, 16'(done), 16'd1);
    chk({tag, "_init_k2"}, 16'(select_initial), 16'd0);
    chk({tag, "_dw"}, dw, exp_dw);
    tick();                                   // edge k+3
    chk({tag, "_upd_k3"}, 16'(select_update), 16'd0);
    chk({tag, "_busy_k3"}, 16'(busy), 16'd0);
    chk({tag, "_dw_hold"}, dw, exp_dw);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; init_req = 1'b0; delta = '0; act = '0;
    start2 = 1'b0; init_req2 = 1'b0; delta2 = '0; act2 = '0;
    tick(); tick();
    chk("rst_dw", dw, 16'h0000);
    chk("rst_upd", 16'(select_update), 16'd0);
    chk("rst_init", 16'(select_initial), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    reset = 1'b0;
    tick();

    // Nominal: 1.0 * 0.5 * 0.5 -> -0.25
    do_mac("nom", 16'sd1024, 16'sd512, 16'sd512, -16'sd256);
    // Floor on negatives
    do_mac("floor", -16'sd1, 16'sd1, -16'sd1, 16'sd1);
    // Saturation of p1
    do_mac("sat", 16'sd31744, 16'sd31744, 16'sd32767, -16'sd16383);

    // Negation saturates with ETA = 1.0
    delta2 = -16'sd32768; act2 = 16'sd1024; start2 = 1'b1;
    tick(); start2 = 1'b0;
    tick(); tick();
    chk("negsat_upd", 16'(select_update2), 16'd1);
    chk("negsat_dw", dw2, 16'sh7FFF);
    tick();

    // Arbitration: init_req wins over start, dw unchanged
    delta = 16'sd1024; act = 16'sd1024; start = 1'b1; init_req = 1'b1;
    tick();
    start = 1'b0; init_req = 1'b0;
    chk("arb_init", 16'(select_initial), 16'd1);
    chk("arb_upd", 16'(select_update), 16'd0);
    chk("arb_busy", 16'(busy), 16'd1);
    tick();
    chk("arb_init_off", 16'(select_initial), 16'd0);
    chk("arb_busy_off", 16'(busy), 16'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin tick(); pulses += int'(select_update); end
    chk("arb_no_upd", 16'(pulses), 16'd0);
    chk("arb_dw", dw, -16'sd16383);

    // Start while in MUL_A is ignored: exactly one update
    delta = 16'sd1024; act = 16'sd512; start = 1'b1;
    tick(); // k: MUL_A
    start = 1'b1;
    tick(); // k+1: ignored
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin pulses += int'(select_update); tick(); end
    chk("ign_pulses", 16'(pulses), 16'd1);
    chk("ign_dw", dw, -16'sd256);

    // Input hold: inputs change right after the accepting edge
    do_mac("pre_hold", -16'sd1, 16'sd1, -16'sd1, 16'sd1);
    delta = 16'sd1024; act = 16'sd512; start = 1'b1;
    tick();
    start = 1'b0; delta = 16'sd31744; act = 16'sd31744;
    tick(); tick();
    chk("hold_upd", 16'(select_update), 16'd1);
    chk("hold_dw", dw, -16'sd256);
    tick();

    // Reset in MUL_B aborts; no later update
    delta = 16'sd31744; act = 16'sd31744; start = 1'b1;
    tick(); start = 1'b0;  // MUL_A
    tick();                // MUL_B
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_dw", dw, 16'h0000);
    chk("abort_upd", 16'(select_update), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin tick(); pulses += int'(select_update); end
    chk("abort_no_upd", 16'(pulses), 16'd0);
    do_mac("post_rst", 16'sd1024, 16'sd512, 16'sd512, -16'sd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
